pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch against a req/ready instruction memory. It replaces the free-running PC register with a three-state sequencer that advances by 4, holds on memory wait or downstream back-pressure, and redirects on branch/jump or trap. It sits between the instruction memory and the decode stage of the single-cycle core. It also turns a misaligned redirect into a trap.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.

- CLK  in  1  single clock, all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  equals PC whenever imem_req is high, else 0.
- imem_ready  in  1  memory returns imem_rdata this cycle; sampled only in FETCH.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  registered instruction available to decode.
- inst  out  32  latched instruction word.
- inst_pc  out  32  address `inst` was fetched from.
- inst_accept  in  1  decode consumes `inst`; sampled only when inst_valid is high.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  32  new PC for the redirect.
- trap  in  1  exception or interrupt request.
- misaligned  out  1  one-cycle registered pulse: a redirect target had bits [1:0] != 0.
- PC  out  32  current fetch PC.

## Operation
- States: IDLE, FETCH, VALID. Encoding is free.
- On reset:
  - State = IDLE; PC = RESET_VECTOR.
  - inst = 0, inst_pc = 0, inst_valid = 0, misaligned = 0, imem_req = 0.
- IDLE: always goes to FETCH on the next edge.
- FETCH: imem_req = 1, imem_addr = PC.
  - If imem_ready is low: hold state and PC.
  - If imem_ready is high: inst <= imem_rdata, inst_pc <= PC, PC <= PC + 4, go to VALID.
- VALID: inst_valid = 1.
  - If inst_accept is low: hold inst, inst_pc, PC and state.
  - If inst_accept is high: go to FETCH.
- Control priority, evaluated every cycle in every state: trap > redirect_valid > normal sequencing.
- Trap:
  - PC <= TRAP_VECTOR; state <= FETCH.
  - inst_valid is 0 next cycle; any held instruction is discarded.
  - imem_rdata returned in the same cycle is dropped and inst/inst_pc are not updated.
- Redirect with redirect_target[1:0] == 0: same as trap, but PC <= redirect_target.
- Redirect with redirect_target[1:0] != 0:
  - Behaves as trap (PC <= TRAP_VECTOR).
  - misaligned = 1 for exactly the next cycle.
- Redirect or trap in IDLE: PC is loaded as above and state goes to FETCH, identical to normal IDLE exit.
- Memory protocol: no outstanding transactions. The request may be withdrawn or re-addressed on any cycle in which imem_ready is low; the memory is required to tolerate this.
- Arithmetic: PC + 4 is 32-bit modulo. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- inst_accept while inst_valid is low is ignored. imem_ready outside FETCH is ignored.

## Timing
- RST asserts asynchronously: all outputs take their reset values immediately, without waiting for a clock edge.
- After RST deasserts: first edge is IDLE→FETCH; imem_req is high in the following cycle.
- Fetch latency: inst_valid rises on the edge after imem_ready is sampled high.
- Best-case throughput: one instruction per 2 cycles (zero-wait memory, inst_accept tied high).
- A redirect or trap takes effect on the next edge. imem_addr shows the new PC in the cycle after the redirect/trap is sampled.
- misaligned is a registered output, asserted in the cycle after the offending redirect.
- inst and inst_pc change only on a successful FETCH completion or on reset.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_VECTOR=0, imem_ready tied high, inst_accept high.
  - Required: imem_addr sequence 0,4,8,C on every other cycle; inst_pc matches; inst_valid pulses alternate cycles.
- Wait states and back-pressure:
  - Stimulus: imem_ready low for 3 cycles at PC=8, then inst_accept low for 2 cycles.
  - Required: imem_addr holds 8 for 4 cycles; inst and inst_valid hold 2 cycles; next request is at 0xC.
- Aligned redirect:
  - Stimulus: redirect_valid with target 0x40 in the same cycle as imem_ready for PC=0x10.
  - Required: data for 0x10 is dropped; next imem_addr is 0x40; inst_pc of the next instruction is 0x40.
- Trap priority and misalignment:
  - Stimulus 1: trap together with redirect to 0x80. Required: PC becomes 0x100.
  - Stimulus 2: redirect to 0x82. Required: PC becomes 0x100 and misaligned is high for exactly 1 cycle.
- Wrap and mid-operation reset:
  - Stimulus 1: redirect to 0xFFFF_FFFC. Required: the following fetch is at 0x0.
  - Stimulus 2: RST asserted while in VALID. Required: inst_valid, inst and PC go to 0 / RESET_VECTOR immediately, before the next CLK edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory handshake, decode hand-off,
// redirect/trap controls and the visible program counter.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_accept;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        misaligned;
    logic [31:0] PC;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, misaligned, PC,
        input  imem_ready, imem_rdata, inst_accept, redirect_valid, redirect_target, trap
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, misaligned, PC,
        output imem_ready, imem_rdata, inst_accept, redirect_valid, redirect_target, trap
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner: IDLE/FETCH/VALID sequencer that fetches one word at a
// time, holds on wait/back-pressure and redirects on trap or branch.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic           CLK,
    input  logic           RST,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        misaligned_q;
    logic        misaligned_nxt;
    logic        load_inst;
    logic        redirect_bad;

    function automatic logic [31:0] pc_inc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

    // State register plus the control registers that move with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            pc           <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misaligned_q <= misaligned_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else if (load_inst) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= pc;
        end
    end

    // Trap beats redirect beats sequencing; a flushing cycle also drops
    // whatever the memory returns in that same cycle.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        misaligned_nxt = 1'b0;
        load_inst      = 1'b0;
        redirect_bad   = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
        if (bus.trap) begin
            state_nxt = FETCH;
            pc_nxt    = TRAP_VECTOR;
        end else if (bus.redirect_valid) begin
            state_nxt      = FETCH;
            pc_nxt         = redirect_bad ? TRAP_VECTOR : bus.redirect_target;
            misaligned_nxt = redirect_bad;
        end else begin
            case (state)
                IDLE: state_nxt = FETCH;
                FETCH: begin
                    if (bus.imem_ready) begin
                        state_nxt = VALID;
                        pc_nxt    = pc_inc(pc);
                        load_inst = 1'b1;
                    end
                end
                VALID: begin
                    if (bus.inst_accept) state_nxt = FETCH;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.imem_req   = (state == FETCH);
        bus.imem_addr  = (state == FETCH) ? pc : 32'h0;
        bus.inst_valid = (state == VALID);
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        bus.misaligned = misaligned_q;
        bus.PC         = pc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural fetch model.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_fail;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: "started" leaves the post-reset idle cycle,
    // "have" says an instruction is sitting in front of decode.
    bit          m_started;
    bit          m_have;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_have    = 1'b0;
        m_mis     = 1'b0;
        m_pc      = RESET_VECTOR;
        m_inst    = 32'h0;
        m_inst_pc = 32'h0;
    endtask

    task automatic model_check();
        bit req;
        req = m_started && !m_have;
        check("imem_req",   {31'h0, bus.imem_req},   {31'h0, req});
        check("imem_addr",  bus.imem_addr,           req ? m_pc : 32'h0);
        check("inst_valid", {31'h0, bus.inst_valid}, {31'h0, m_have});
        check("inst",       bus.inst,                m_inst);
        check("inst_pc",    bus.inst_pc,             m_inst_pc);
        check("misaligned", {31'h0, bus.misaligned}, {31'h0, m_mis});
        check("PC",         bus.PC,                  m_pc);
    endtask

    task automatic model_step();
        m_mis = 1'b0;
        if (bus.trap) begin
            m_pc = TRAP_VECTOR; m_started = 1'b1; m_have = 1'b0;
        end else if (bus.redirect_valid) begin
            if (bus.redirect_target[1:0] != 2'b00) begin
                m_pc  = TRAP_VECTOR;
                m_mis = 1'b1;
            end else begin
                m_pc = bus.redirect_target;
            end
            m_started = 1'b1; m_have = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_have) begin
            if (bus.imem_ready) begin
                m_inst    = bus.imem_rdata;
                m_inst_pc = m_pc;
                m_pc      = m_pc + 32'd4;
                m_have    = 1'b1;
            end
        end else if (bus.inst_accept) begin
            m_have = 1'b0;
        end
    endtask

    // One clock: check current outputs, take the edge, advance the model.
    task automatic cycle();
        model_check();
        @(posedge CLK);
        model_step();
        #1;
        bus.imem_rdata = $urandom;
    endtask

    task automatic set_in(input bit rdy, input bit acc, input bit trp, input bit rv,
                          input logic [31:0] tgt);
        bus.imem_ready      = rdy;
        bus.inst_accept     = acc;
        bus.trap            = trp;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
    endtask

    task automatic check_reset_values();
        check("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        check("rst_imem_req",   {31'h0, bus.imem_req},   32'h0);
        check("rst_imem_addr",  bus.imem_addr,           32'h0);
        check("rst_inst",       bus.inst,                32'h0);
        check("rst_inst_pc",    bus.inst_pc,             32'h0);
        check("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
        check("rst_PC",         bus.PC,                  RESET_VECTOR);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        RST    = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.imem_rdata = 32'h0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        // Sequential fetch with zero-wait memory and decode always accepting.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) cycle();
        check("seq_addr_8", bus.imem_addr, 32'h8);

        // Three wait states at PC=8, then two cycles of back-pressure.
        bus.imem_ready = 1'b0;
        repeat (3) begin
            check("wait_addr_8", bus.imem_addr, 32'h8);
            cycle();
        end
        check("wait_addr_8_last", bus.imem_addr, 32'h8);
        bus.imem_ready = 1'b1;
        cycle();
        bus.inst_accept = 1'b0;
        repeat (2) cycle();
        check("bp_inst_pc", bus.inst_pc, 32'h8);
        bus.inst_accept = 1'b1;
        cycle();
        check("after_bp_addr_C", bus.imem_addr, 32'hC);

        // Aligned redirect coinciding with a completed fetch at 0x10.
        repeat (2) cycle();
        check("pre_redir_addr", bus.imem_addr, 32'h10);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_addr_40", bus.imem_addr, 32'h40);
        check("redir_dropped_pc", bus.inst_pc, 32'hC);
        cycle();
        check("redir_inst_pc_40", bus.inst_pc, 32'h40);

        // Trap outranks a simultaneous redirect.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
        cycle();
        check("trap_prio_PC", bus.PC, TRAP_VECTOR);

        // Misaligned redirect becomes a trap and pulses misaligned once.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h82);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("mis_PC", bus.PC, TRAP_VECTOR);
        check("mis_pulse", {31'h0, bus.misaligned}, 32'h1);
        cycle();
        check("mis_cleared", {31'h0, bus.misaligned}, 32'h0);

        // PC wraps from 0xFFFF_FFFC to 0.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle();
        cycle();
        check("wrap_next_addr", bus.imem_addr, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
                   {$urandom_range(0, 2**20 - 1), 10'h0, 2'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0)});
            cycle();
        end

        // Mid-operation asynchronous reset while an instruction is held.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20 && !m_have; i++) cycle();
        check("reach_valid", {31'h0, bus.inst_valid}, 32'h1);
        #1;
        RST = 1'b1;
        #1;
        check_reset_values();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) cycle();
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
